// File: rtl/cache_perf_pkg.sv
// Shared FSM encoding, result-word map and saturating helper for cache_perf_monitor.
// Defining CACHE_PERF_STREAK_EN adds the miss-streak word, which is emitted last.
package cache_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [2:0] IDX_ACC    = 3'd0;
    localparam logic [2:0] IDX_L1     = 3'd1;
    localparam logic [2:0] IDX_L2     = 3'd2;
    localparam logic [2:0] IDX_MEM    = 3'd3;
    localparam logic [2:0] IDX_STREAK = 3'd4;

`ifdef CACHE_PERF_STREAK_EN
    localparam int unsigned NUM_WORDS = 32'd5;
`else
    localparam int unsigned NUM_WORDS = 32'd4;
`endif

    localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 32'd1);

    // Callers widen to 64 bits and pass their own all-ones ceiling.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
        if (val >= max_val) begin
            return val;
        end else begin
            return val + 64'd1;
        end
    endfunction

endpackage

// File: rtl/cache_perf_if.sv
// Access-outcome input and result-stream output of cache_perf_monitor.
// master = the monitor, slave = the producer of accesses / consumer of results.
interface cache_perf_if #(parameter int CNT_W = 32);
    logic             acc_valid;
    logic             l1_hit;
    logic             l2_hit;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_idx;
    logic [CNT_W-1:0] out_data;
    logic             out_last;

    modport master (
        input  acc_valid, l1_hit, l2_hit, out_ready,
        output out_valid, out_idx, out_data, out_last
    );

    modport slave (
        output acc_valid, l1_hit, l2_hit, out_ready,
        input  out_valid, out_idx, out_data, out_last
    );
endinterface

// File: rtl/cache_perf_monitor_sat_counter.sv
// Saturating statistics counter with synchronous clear; clear wins over increment.
// cnt_nxt is the value the register takes at the coming edge.
module sat_counter
    import cache_perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_nxt
);

    localparam logic [63:0] MAX_V = 64'({CNT_W{1'b1}});

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next-count selection.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = CNT_W'(sat_inc(64'(cnt_q), MAX_V));
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_nxt = cnt_d;

endmodule

// File: rtl/cache_perf_monitor.sv
// Cache statistics window: counts L1/L2/memory outcomes in RUN, then streams them out in DRAIN.
// Optional CACHE_PERF_STREAK_EN adds the longest consecutive-L1-miss run as an extra word.
module cache_perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int WINDOW_LEN = 1024,
    parameter int WIN_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    output logic         busy,
    cache_perf_if.master bus
);
    import cache_perf_pkg::*;

    localparam logic             AUTO_CLOSE = (WINDOW_LEN != 32'sd0);
    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_LEN);
    localparam logic [63:0]      MAX_V      = 64'({CNT_W{1'b1}});

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [CNT_W-1:0] out_data_q, out_data_d;
    logic             clr_s, cnt_acc_s, close_s;
    logic             inc_l1_s, inc_l2_s, inc_mem_s;
    logic [CNT_W-1:0] n_acc_s, n_l1_s, n_l2_s, n_mem_s, word_s;

    sat_counter #(.CNT_W(CNT_W)) u_acc (.clk(clk), .rst(rst), .clr(clr_s), .inc(cnt_acc_s), .cnt_nxt(n_acc_s));
    sat_counter #(.CNT_W(CNT_W)) u_l1  (.clk(clk), .rst(rst), .clr(clr_s), .inc(inc_l1_s),  .cnt_nxt(n_l1_s));
    sat_counter #(.CNT_W(CNT_W)) u_l2  (.clk(clk), .rst(rst), .clr(clr_s), .inc(inc_l2_s),  .cnt_nxt(n_l2_s));
    sat_counter #(.CNT_W(CNT_W)) u_mem (.clk(clk), .rst(rst), .clr(clr_s), .inc(inc_mem_s), .cnt_nxt(n_mem_s));

    // Access classification and window counting; l1_hit has priority over l2_hit.
    always_comb begin
        cnt_acc_s = (state_q == ST_RUN) && bus.acc_valid;
        inc_l1_s  = cnt_acc_s && bus.l1_hit;
        inc_l2_s  = cnt_acc_s && !bus.l1_hit && bus.l2_hit;
        inc_mem_s = cnt_acc_s && !bus.l1_hit && !bus.l2_hit;
        close_s   = AUTO_CLOSE && cnt_acc_s && ((win_q + WIN_W'(1'b1)) == WIN_LAST);
        if (clr_s) begin
            win_d = '0;
        end else if (cnt_acc_s) begin
            win_d = win_q + WIN_W'(1'b1);
        end else begin
            win_d = win_q;
        end
    end

`ifdef CACHE_PERF_STREAK_EN
    logic [CNT_W-1:0] run_q, run_d, streak_q, streak_d;

    // Current miss run and its maximum; an L1 hit ends the run.
    always_comb begin
        run_d    = run_q;
        streak_d = streak_q;
        if (clr_s) begin
            run_d    = '0;
            streak_d = '0;
        end else if (cnt_acc_s && bus.l1_hit) begin
            run_d = '0;
        end else if (cnt_acc_s) begin
            run_d = CNT_W'(sat_inc(64'(run_q), MAX_V));
            if (run_d > streak_q) begin
                streak_d = run_d;
            end else begin
                streak_d = streak_q;
            end
        end else begin
            run_d = run_q;
        end
    end

    // Streak registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q    <= '0;
            streak_q <= '0;
        end else begin
            run_q    <= run_d;
            streak_q <= streak_d;
        end
    end
`endif

    // Window FSM; start overrides every state, including an unfinished drain.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_s   = 1'b0;
        if (start) begin
            state_d = ST_RUN;
            idx_d   = 3'd0;
            clr_s   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    if (stop || close_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.out_ready && idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = 3'd0;
                    end else if (bus.out_ready) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        idx_d = idx_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Result word for the next cycle; counter look-ahead catches the closing access.
    always_comb begin
        case (idx_d)
            IDX_ACC:    word_s = n_acc_s;
            IDX_L1:     word_s = n_l1_s;
            IDX_L2:     word_s = n_l2_s;
            IDX_MEM:    word_s = n_mem_s;
`ifdef CACHE_PERF_STREAK_EN
            IDX_STREAK: word_s = streak_d;
`endif
            default:    word_s = '0;
        endcase
        busy_d      = (state_d == ST_RUN);
        out_valid_d = (state_d == ST_DRAIN);
        out_last_d  = out_valid_d && (idx_d == LAST_IDX);
        if (out_valid_d) begin
            out_data_d = word_s;
        end else begin
            out_data_d = '0;
        end
    end

    // State, window count and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            win_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            win_q       <= win_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy          = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_cache_perf_monitor.sv
// Scoreboard bench: dut_a (32-bit, no auto-close) and dut_b (3-bit counters, 10-access window).
// Expected result words are queued at stimulus time and popped by per-DUT monitors on handshakes.
module tb_cache_perf_monitor;

`ifdef CACHE_PERF_STREAK_EN
    localparam int NW = 5;
`else
    localparam int NW = 4;
`endif
    localparam int K_L1 = 0;
    localparam int K_L2 = 1;
    localparam int K_MEM = 2;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, stop = 1'b0, acc_valid = 1'b0, l1_hit = 1'b0, l2_hit = 1'b0;
    logic out_ready = 1'b1, sel_b = 1'b0;
    logic busy_a, busy_b;
    int   n_vec = 0, n_err = 0;
    exp_t q_a[$], q_b[$];

    cache_perf_if #(.CNT_W(32)) bus_a ();
    cache_perf_if #(.CNT_W(3))  bus_b ();

    assign bus_a.acc_valid = acc_valid & ~sel_b;
    assign bus_a.l1_hit    = l1_hit;
    assign bus_a.l2_hit    = l2_hit;
    assign bus_a.out_ready = out_ready;
    assign bus_b.acc_valid = acc_valid & sel_b;
    assign bus_b.l1_hit    = l1_hit;
    assign bus_b.l2_hit    = l2_hit;
    assign bus_b.out_ready = out_ready;

    cache_perf_monitor #(.CNT_W(32), .WINDOW_LEN(0), .WIN_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel_b), .stop(stop & ~sel_b),
        .busy(busy_a), .bus(bus_a.master));

    cache_perf_monitor #(.CNT_W(3), .WINDOW_LEN(10), .WIN_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel_b), .stop(stop & sel_b),
        .busy(busy_b), .bus(bus_b.master));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit to_b, input int acc, input int l1, input int l2,
                            input int mem, input int streak);
        int   vals[5];
        exp_t e;
        vals = '{acc, l1, l2, mem, streak};
        for (int i = 0; i < NW; i++) begin
            e.idx  = 3'(i);
            e.data = 32'(vals[i]);
            e.last = (i == NW - 1);
            if (to_b) q_b.push_back(e);
            else      q_a.push_back(e);
        end
    endtask

    // Handshake monitor for dut_a.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst && bus_a.out_valid && bus_a.out_ready) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_word_idx", 32'(bus_a.out_idx), 32'hFFFF_FFFF);
            end else begin
                e = q_a.pop_front();
                check("a_idx",  32'(bus_a.out_idx),  32'(e.idx));
                check("a_data", bus_a.out_data,      e.data);
                check("a_last", 32'(bus_a.out_last), 32'(e.last));
            end
        end
    end

    // Handshake monitor for dut_b.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst && bus_b.out_valid && bus_b.out_ready) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_word_idx", 32'(bus_b.out_idx), 32'hFFFF_FFFF);
            end else begin
                e = q_b.pop_front();
                check("b_idx",  32'(bus_b.out_idx),  32'(e.idx));
                check("b_data", 32'(bus_b.out_data), e.data);
                check("b_last", 32'(bus_b.out_last), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int kind);
        acc_valid = 1'b1;
        l1_hit    = (kind == K_L1);
        l2_hit    = (kind != K_MEM);  // L1 accesses also raise l2_hit, which must be ignored
        tick();
        acc_valid = 1'b0;
        l1_hit    = 1'b0;
        l2_hit    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_drained(input bit to_b);
        int left;
        left = to_b ? q_b.size() : q_a.size();
        for (int i = 0; i < 60 && left > 0; i++) begin
            @(posedge clk);
            left = to_b ? q_b.size() : q_a.size();
        end
        #1;
        check(to_b ? "b_words_left" : "a_words_left", 32'(left), 32'd0);
        check(to_b ? "b_valid_after_drain" : "a_valid_after_drain",
              32'(to_b ? bus_b.out_valid : bus_a.out_valid), 32'd0);
    endtask

    initial begin
        int pat1[8];
        int pat3[6];
        pat1 = '{K_L1, K_L1, K_L2, K_MEM, K_L1, K_MEM, K_L2, K_L1};
        pat3 = '{K_MEM, K_L2, K_MEM, K_L1, K_MEM, K_MEM};

        // Reset state
        repeat (2) tick();
        check("rst_busy",      32'(busy_a),          32'd0);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_out_idx",   32'(bus_a.out_idx),   32'd0);
        check("rst_out_data",  bus_a.out_data,       32'd0);
        check("rst_out_last",  32'(bus_a.out_last),  32'd0);
        rst = 1'b1;
        tick();

        // Idle: stop and accesses are ignored
        pulse_stop();
        check("idle_stop_busy", 32'(busy_a), 32'd0);
        access(K_L1);
        access(K_MEM);
        check("idle_acc_valid", 32'(bus_a.out_valid), 32'd0);

        // Mixed pattern, closed by stop
        pulse_start();
        check("run_busy", 32'(busy_a), 32'd1);
        foreach (pat1[i]) access(pat1[i]);
        check("run_busy_before_stop", 32'(busy_a), 32'd1);
        push_exp(1'b0, 8, 4, 2, 2, 2);
        pulse_stop();
        check("drain_busy", 32'(busy_a), 32'd0);
        wait_drained(1'b0);

        // Back-pressure, stepping, then start aborting the drain at idx 2
        out_ready = 1'b0;
        pulse_start();
        foreach (pat3[i]) access(pat3[i]);
        push_exp(1'b0, 6, 1, 1, 4, 3);
        pulse_stop();
        for (int c = 0; c < 5; c++) begin
            check("stall_idx",  32'(bus_a.out_idx), 32'd0);
            check("stall_data", bus_a.out_data,      32'd6);
            tick();
        end
        for (int k = 1; k <= 2; k++) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("step_idx", 32'(bus_a.out_idx), 32'(k));
            tick();
            check("step_hold_idx", 32'(bus_a.out_idx), 32'(k));
        end
        check("step_idx2_data", bus_a.out_data, 32'd1);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("abort_busy",      32'(busy_a),          32'd1);
        check("abort_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("abort_out_idx",   32'(bus_a.out_idx),   32'd0);
        q_a.delete();
        out_ready = 1'b1;
        push_exp(1'b0, 0, 0, 0, 0, 0);
        pulse_stop();
        wait_drained(1'b0);

        // Asynchronous reset between clock edges in RUN
        pulse_start();
        access(K_L1);
        access(K_MEM);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_busy",  32'(busy_a),          32'd0);
        check("async_rst_valid", 32'(bus_a.out_valid), 32'd0);
        tick();
        rst = 1'b1;
        access(K_L1);
        check("post_rst_idle_busy", 32'(busy_a), 32'd0);

        // dut_b: counters saturate at 7, window still closes on the 10th access
        sel_b = 1'b1;
        pulse_start();
        push_exp(1'b1, 7, 7, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            access(K_L1);
            check("b_busy_after_access", 32'(busy_b), (k < 10) ? 32'd1 : 32'd0);
        end
        wait_drained(1'b1);
        sel_b = 1'b0;

        check("a_queue_empty", 32'(q_a.size()), 32'd0);
        check("b_queue_empty", 32'(q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected to have finished", $time);
        $fatal(1, "time limit reached");
    end

endmodule
